// File: rtl/axi4_full_slave_ram_if.sv
// AXI4-full bus bundle between a burst master and axi4_full_slave_ram.
interface axi4_full_slave_ram_if #(
  parameter int unsigned S_AXI_ID_WIDTH   = 3,
  parameter int unsigned S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned S_AXI_DATA_WIDTH = 128
);
  logic [S_AXI_ID_WIDTH-1:0]     awid;
  logic [S_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize;
  logic [1:0]                    awburst;
  logic                          awlock;
  logic [3:0]                    awcache;
  logic [2:0]                    awprot;
  logic [3:0]                    awqos;
  logic                          awvalid;
  logic                          awready;
  logic [S_AXI_ID_WIDTH-1:0]     wid;
  logic [S_AXI_DATA_WIDTH-1:0]   wdata;
  logic [S_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                          wlast;
  logic                          wvalid;
  logic                          wready;
  logic [S_AXI_ID_WIDTH-1:0]     bid;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;
  logic [S_AXI_ID_WIDTH-1:0]     arid;
  logic [S_AXI_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic                          arlock;
  logic [3:0]                    arcache;
  logic [2:0]                    arprot;
  logic [3:0]                    arqos;
  logic                          arvalid;
  logic                          arready;
  logic [S_AXI_ID_WIDTH-1:0]     rid;
  logic [S_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_full_slave_ram.sv
// AXI4-full slave backed by a byte-enabled RAM; independent write and read burst engines,
// one outstanding burst per direction, read-first on same-word collisions.
module axi4_full_slave_ram #(
  parameter int unsigned S_AXI_ID_WIDTH   = 3,
  parameter int unsigned S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned S_AXI_DATA_WIDTH = 128,
  parameter int unsigned MEM_DEPTH_LOG2   = 10
) (
  input logic                  s_axi_aclk,
  input logic                  s_axi_areset,
  axi4_full_slave_ram_if.slave s_axi
);
  localparam int unsigned StrbWidth = S_AXI_DATA_WIDTH / 8;
  localparam int unsigned ByteLsb   = $clog2(StrbWidth);
  localparam int unsigned IdxHi     = MEM_DEPTH_LOG2 + ByteLsb - 1;
  localparam int unsigned Depth     = 1 << MEM_DEPTH_LOG2;

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {StWIdle, StWData, StWResp} wstate_e;
  typedef enum logic [1:0] {StRIdle, StRFetch, StRData} rstate_e;

  logic [S_AXI_DATA_WIDTH-1:0] mem [Depth];
  logic [S_AXI_DATA_WIDTH-1:0] rdata_q;

  wstate_e                   wstate_q, wstate_d;
  idx_t                      widx_q, widx_d;
  logic [7:0]                wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [S_AXI_ID_WIDTH-1:0] wid_q, wid_d;
  logic                      wfixed_q, wfixed_d, werr_q, werr_d, wen;

  rstate_e                   rstate_q, rstate_d;
  idx_t                      ridx_q, ridx_d;
  logic [7:0]                rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [S_AXI_ID_WIDTH-1:0] rid_q, rid_d;
  logic                      rfixed_q, rfixed_d, ren;

  logic unused_sigs;
  assign unused_sigs = ^{s_axi.awsize, s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                         s_axi.arsize, s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos,
                         s_axi.wid, s_axi.awaddr[S_AXI_ADDR_WIDTH-1:IdxHi+1],
                         s_axi.awaddr[ByteLsb-1:0], s_axi.araddr[S_AXI_ADDR_WIDTH-1:IdxHi+1],
                         s_axi.araddr[ByteLsb-1:0]};

  // Write engine: burst length comes from AWLEN; WLAST is only checked, never trusted.
  always_comb begin
    wstate_d      = wstate_q;
    widx_d        = widx_q;
    wlen_d        = wlen_q;
    wcnt_d        = wcnt_q;
    wid_d         = wid_q;
    wfixed_d      = wfixed_q;
    werr_d        = werr_q;
    wen           = 1'b0;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    s_axi.bid     = '0;
    s_axi.bresp   = 2'b00;
    unique case (wstate_q)
      StWIdle: begin
        s_axi.awready = 1'b1;
        if (s_axi.awvalid) begin
          widx_d   = s_axi.awaddr[IdxHi:ByteLsb];
          wlen_d   = s_axi.awlen;
          wid_d    = s_axi.awid;
          wfixed_d = (s_axi.awburst == 2'b00);
          wcnt_d   = 8'd0;
          werr_d   = 1'b0;
          wstate_d = StWData;
        end
      end
      StWData: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid) begin
          wen    = 1'b1;
          werr_d = werr_q | (s_axi.wlast != (wcnt_q == wlen_q));
          widx_d = wfixed_q ? widx_q : widx_q + idx_t'(1);
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_q == wlen_q) wstate_d = StWResp;
        end
      end
      StWResp: begin
        s_axi.bvalid = 1'b1;
        s_axi.bid    = wid_q;
        s_axi.bresp  = werr_q ? 2'b10 : 2'b00;
        if (s_axi.bready) wstate_d = StWIdle;
      end
      default: wstate_d = StWIdle;
    endcase
    if (s_axi_areset) begin
      s_axi.awready = 1'b0;
      s_axi.wready  = 1'b0;
      s_axi.bvalid  = 1'b0;
      s_axi.bid     = '0;
      s_axi.bresp   = 2'b00;
      wen           = 1'b0;
    end
  end

  // Read engine: the RAM word for the next beat is fetched on the accepting handshake.
  always_comb begin
    rstate_d      = rstate_q;
    ridx_d        = ridx_q;
    rlen_d        = rlen_q;
    rcnt_d        = rcnt_q;
    rid_d         = rid_q;
    rfixed_d      = rfixed_q;
    ren           = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    s_axi.rlast   = 1'b0;
    s_axi.rid     = '0;
    s_axi.rdata   = '0;
    s_axi.rresp   = 2'b00;
    unique case (rstate_q)
      StRIdle: begin
        s_axi.arready = 1'b1;
        if (s_axi.arvalid) begin
          ridx_d   = s_axi.araddr[IdxHi:ByteLsb];
          rlen_d   = s_axi.arlen;
          rid_d    = s_axi.arid;
          rfixed_d = (s_axi.arburst == 2'b00);
          rcnt_d   = 8'd0;
          rstate_d = StRFetch;
        end
      end
      StRFetch: begin
        ren      = 1'b1;
        ridx_d   = rfixed_q ? ridx_q : ridx_q + idx_t'(1);
        rstate_d = StRData;
      end
      StRData: begin
        s_axi.rvalid = 1'b1;
        s_axi.rlast  = (rcnt_q == rlen_q);
        s_axi.rid    = rid_q;
        s_axi.rdata  = rdata_q;
        if (s_axi.rready) begin
          if (rcnt_q == rlen_q) begin
            rstate_d = StRIdle;
          end else begin
            ren    = 1'b1;
            ridx_d = rfixed_q ? ridx_q : ridx_q + idx_t'(1);
            rcnt_d = rcnt_q + 8'd1;
          end
        end
      end
      default: rstate_d = StRIdle;
    endcase
    if (s_axi_areset) begin
      s_axi.arready = 1'b0;
      s_axi.rvalid  = 1'b0;
      s_axi.rlast   = 1'b0;
      s_axi.rid     = '0;
      s_axi.rdata   = '0;
      ren           = 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wstate_q <= StWIdle;
      widx_q   <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wid_q    <= '0;
      wfixed_q <= 1'b0;
      werr_q   <= 1'b0;
      rstate_q <= StRIdle;
      ridx_q   <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rid_q    <= '0;
      rfixed_q <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      widx_q   <= widx_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      wid_q    <= wid_d;
      wfixed_q <= wfixed_d;
      werr_q   <= werr_d;
      rstate_q <= rstate_d;
      ridx_q   <= ridx_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rid_q    <= rid_d;
      rfixed_q <= rfixed_d;
    end
  end

  // RAM is never reset; non-blocking read gives old data on a same-cycle write.
  always_ff @(posedge s_axi_aclk) begin
    if (wen) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (s_axi.wstrb[b]) mem[widx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
    if (ren) rdata_q <= mem[ridx_q];
  end
endmodule

// File: tb/tb_axi4_full_slave_ram.sv
// Directed bench for axi4_full_slave_ram: vector table of write/read-back bursts plus
// hand sequences for latency, strobes, WLAST errors, backpressure and mid-burst reset.
module tb_axi4_full_slave_ram;
  localparam int unsigned IdW = 3;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 128;
  localparam int unsigned DepthLog2 = 10;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4_full_slave_ram_if #(.S_AXI_ID_WIDTH(IdW), .S_AXI_ADDR_WIDTH(AddrW),
                           .S_AXI_DATA_WIDTH(DataW)) bus ();

  axi4_full_slave_ram #(.S_AXI_ID_WIDTH(IdW), .S_AXI_ADDR_WIDTH(AddrW),
                        .S_AXI_DATA_WIDTH(DataW), .MEM_DEPTH_LOG2(DepthLog2)) dut (
    .s_axi_aclk  (clk),
    .s_axi_areset(rst),
    .s_axi       (bus)
  );

  logic [127:0] model [1024];
  logic [127:0] wq [$];

  typedef struct {
    logic [31:0]  waddr;
    logic [7:0]   wlen;
    logic [2:0]   wid;
    logic [1:0]   wburst;
    int           base;
    bit           do_read;
    logic [31:0]  raddr;
    logic [7:0]   rlen;
    logic [2:0]   rid;
    logic [1:0]   rburst;
    bit           toggle;
    logic [1:0]   exp_bresp;
    logic [127:0] exp_first;
    logic [127:0] exp_last;
  } vec_t;

  function automatic logic [127:0] pat(input int v);
    return {4{v[31:0]}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id,
                           input logic [1:0] burst, input logic [15:0] strb, input int last_beat,
                           input int bhold, output logic [1:0] resp, output logic [2:0] bid_o,
                           output int turn);
    int n;
    int k;
    logic [9:0] idx;
    @(negedge clk);
    bus.awaddr = addr; bus.awlen = len; bus.awid = id; bus.awburst = burst;
    bus.awsize = 3'd4; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 100) begin @(negedge clk); n++; end
    chk("aw_accept", 128'(bus.awready), 128'(1));
    k = cyc;
    idx = addr[13:4];
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wvalid = 1'b1; bus.wdata = wq[i]; bus.wstrb = strb; bus.wlast = (i == last_beat);
      n = 0;
      while (!bus.wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("w_accept", 128'(bus.wready), 128'(1));
      for (int b = 0; b < 16; b++) if (strb[b]) model[idx][b*8 +: 8] = wq[i][b*8 +: 8];
      if (burst != 2'b00) idx++;
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 100) begin @(negedge clk); n++; end
    chk("b_valid", 128'(bus.bvalid), 128'(1));
    for (int d = 0; d < bhold; d++) begin
      chk("b_hold_valid", 128'(bus.bvalid), 128'(1));
      chk("b_hold_bid", 128'(bus.bid), 128'(id));
      chk("b_hold_awready", 128'(bus.awready), 128'(0));
      @(negedge clk);
    end
    resp = bus.bresp;
    bid_o = bus.bid;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    turn = cyc - k;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id,
                          input logic [1:0] burst, input bit toggle,
                          output logic [127:0] first_d, output logic [127:0] last_d);
    int n, k, got, step, fc, lc;
    logic [9:0] idx;
    logic [127:0] held;
    bit stalled, rr;
    first_d = '0; last_d = '0;
    @(negedge clk);
    bus.araddr = addr; bus.arlen = len; bus.arid = id; bus.arburst = burst;
    bus.arsize = 3'd4; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 100) begin @(negedge clk); n++; end
    chk("ar_accept", 128'(bus.arready), 128'(1));
    k = cyc;
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("r_fetch_idle", 128'(bus.rvalid), 128'(0));
    idx = addr[13:4];
    got = 0; step = 0; stalled = 1'b0; n = 0; fc = -1; lc = 0; held = '0;
    while (got <= int'(len) && n < 2000) begin
      @(negedge clk);
      n++;
      rr = toggle ? (step % 2 == 0) : 1'b1;
      step++;
      if (bus.rvalid) begin
        if (fc < 0) begin
          fc = cyc;
          chk("r_first_latency", 128'(cyc - k), 128'(2));
        end
        if (stalled) chk("r_stall_hold", bus.rdata, held);
        if (rr) begin
          chk("r_data", bus.rdata, model[idx]);
          chk("r_last", 128'(bus.rlast), 128'(got == int'(len)));
          chk("r_id", 128'(bus.rid), 128'(id));
          chk("r_resp", 128'(bus.rresp), 128'(0));
          if (got == 0) first_d = bus.rdata;
          last_d = bus.rdata;
          lc = cyc;
          if (burst != 2'b00) idx++;
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = bus.rdata;
        end
      end
      bus.rready = rr;
    end
    chk("r_complete", 128'(got), 128'(int'(len) + 1));
    if (!toggle) chk("r_no_gaps", 128'(lc - fc), 128'(int'(len)));
    @(negedge clk);
    bus.rready = 1'b0;
    chk("r_done_rvalid", 128'(bus.rvalid), 128'(0));
    chk("r_done_arready", 128'(bus.arready), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    logic [1:0] resp;
    logic [2:0] bid;
    logic [127:0] fd, ld;
    int turn, n, got;

    vecs[0] = '{32'h400, 8'd63, 3'd1, 2'b01, 32'h1000, 1'b0, 32'h0, 8'd0, 3'd0, 2'b01, 1'b0,
                2'b00, '0, '0};
    vecs[1] = '{32'h800, 8'd35, 3'd2, 2'b01, 32'h1040, 1'b1, 32'h400, 8'd99, 3'd3, 2'b01, 1'b0,
                2'b00, pat(32'h1000), pat(32'h1063)};
    vecs[2] = '{32'h3FE0, 8'd3, 3'd4, 2'b01, 32'h2000, 1'b1, 32'h13FE0, 8'd3, 3'd5, 2'b01, 1'b0,
                2'b00, pat(32'h2000), pat(32'h2003)};
    vecs[3] = '{32'h200, 8'd3, 3'd6, 2'b00, 32'h3000, 1'b1, 32'h200, 8'd2, 3'd7, 2'b00, 1'b0,
                2'b00, pat(32'h3003), pat(32'h3003)};
    vecs[4] = '{32'h600, 8'd7, 3'd0, 2'b01, 32'h4000, 1'b1, 32'h600, 8'd7, 3'd1, 2'b01, 1'b1,
                2'b00, pat(32'h4000), pat(32'h4007)};

    rst = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_awready", 128'(bus.awready), 128'(0));
    chk("rst_arready", 128'(bus.arready), 128'(0));
    chk("rst_wready", 128'(bus.wready), 128'(0));
    chk("rst_bvalid", 128'(bus.bvalid), 128'(0));
    chk("rst_rvalid", 128'(bus.rvalid), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", 128'(bus.awready), 128'(1));
    chk("post_rst_arready", 128'(bus.arready), 128'(1));

    // Basic 4-beat write then read-back with latency and AW turnaround checks.
    wq.delete();
    for (int i = 1; i <= 4; i++) wq.push_back(128'(i));
    axi_write(32'h100, 8'd3, 3'd5, 2'b01, 16'hFFFF, 3, 0, resp, bid, turn);
    chk("t1_bresp", 128'(resp), 128'(2'b00));
    chk("t1_bid", 128'(bid), 128'(5));
    chk("t1_aw_turnaround", 128'(turn), 128'(6));
    axi_read(32'h100, 8'd3, 3'd2, 2'b01, 1'b0, fd, ld);
    chk("t1_first", fd, 128'(1));
    chk("t1_last", ld, 128'(4));

    for (int v = 0; v < 5; v++) begin
      wq.delete();
      for (int i = 0; i <= int'(vecs[v].wlen); i++) wq.push_back(pat(vecs[v].base + i));
      axi_write(vecs[v].waddr, vecs[v].wlen, vecs[v].wid, vecs[v].wburst, 16'hFFFF,
                int'(vecs[v].wlen), 0, resp, bid, turn);
      chk("vec_bresp", 128'(resp), 128'(vecs[v].exp_bresp));
      chk("vec_bid", 128'(bid), 128'(vecs[v].wid));
      if (vecs[v].do_read) begin
        axi_read(vecs[v].raddr, vecs[v].rlen, vecs[v].rid, vecs[v].rburst, vecs[v].toggle, fd, ld);
        chk("vec_first", fd, vecs[v].exp_first);
        chk("vec_last", ld, vecs[v].exp_last);
      end
    end

    // Byte strobes: only the low 8 bytes get overwritten.
    wq.delete(); wq.push_back({128{1'b1}});
    axi_write(32'h1000, 8'd0, 3'd1, 2'b01, 16'hFFFF, 0, 0, resp, bid, turn);
    wq.delete(); wq.push_back(128'd0);
    axi_write(32'h1000, 8'd0, 3'd1, 2'b01, 16'h00FF, 0, 0, resp, bid, turn);
    axi_read(32'h1000, 8'd0, 3'd1, 2'b01, 1'b0, fd, ld);
    chk("strb_merge", fd, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

    // Early WLAST: every beat still lands, response is SLVERR, next burst is clean.
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(pat(32'h5000 + i));
    axi_write(32'h1100, 8'd3, 3'd2, 2'b01, 16'hFFFF, 1, 0, resp, bid, turn);
    chk("wlast_err_bresp", 128'(resp), 128'(2'b10));
    axi_read(32'h1100, 8'd3, 3'd2, 2'b01, 1'b0, fd, ld);
    chk("wlast_err_last_beat", ld, pat(32'h5003));
    axi_write(32'h1140, 8'd3, 3'd3, 2'b01, 16'hFFFF, 3, 0, resp, bid, turn);
    chk("wlast_ok_bresp", 128'(resp), 128'(2'b00));

    // B backpressure for 5 cycles.
    wq.delete(); wq.push_back(pat(32'h6000)); wq.push_back(pat(32'h6001));
    axi_write(32'h1200, 8'd1, 3'd3, 2'b01, 16'hFFFF, 1, 5, resp, bid, turn);
    chk("bhold_bresp", 128'(resp), 128'(2'b00));
    chk("bhold_bid", 128'(bid), 128'(3));

    // Reset in the middle of an 8-beat read at beat 3.
    @(negedge clk);
    bus.araddr = 32'h600; bus.arlen = 8'd7; bus.arid = 3'd4; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 100) begin @(negedge clk); n++; end
    chk("rst_mid_ar_accept", 128'(bus.arready), 128'(1));
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    got = 0; n = 0;
    while (got < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.rvalid) begin
        chk("rst_mid_data", bus.rdata, pat(32'h4000 + got));
        got++;
      end
    end
    chk("rst_mid_beats", 128'(got), 128'(3));
    rst = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    chk("rst_mid_rvalid", 128'(bus.rvalid), 128'(0));
    chk("rst_mid_arready", 128'(bus.arready), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_arready_after", 128'(bus.arready), 128'(1));
    chk("rst_mid_rvalid_after", 128'(bus.rvalid), 128'(0));
    axi_read(32'h600, 8'd7, 3'd5, 2'b01, 1'b0, fd, ld);
    chk("rst_mid_reread_first", fd, pat(32'h4000));
    chk("rst_mid_reread_last", ld, pat(32'h4007));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi4_full_slave_ram.md
Name: axi4_full_slave_ram

Overview:
- AXI4-full slave responder backed by an on-chip RAM.
- It is the far end of the burst protocol driven by the team's FDMA master: it accepts INCR bursts of up to 256 beats on AW/W/B and AR/R.
- It answers with write responses and read data.
- Used as the DDR stand-in for FDMA simulation and as a BRAM frame/line store behind the master in small designs.
- Read and write channels run independently, with one outstanding burst per direction.

Parameters:
S_AXI_ID_WIDTH, 3, width of all ID fields
S_AXI_ADDR_WIDTH, 32, byte address width
S_AXI_DATA_WIDTH, 128, data width in bits (power of 2, at least 32)
MEM_DEPTH_LOG2, 10, log2 of the RAM depth in data words

Ports:
S_AXI_ACLK  in  1  single clock
S_AXI_ARESET  in  1  synchronous reset, active-high
S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/8/3/2  write address
S_AXI_AWLOCK/AWCACHE/AWPROT/AWQOS  in  1/4/3/4  accepted, ignored
S_AXI_AWVALID  in  1;  S_AXI_AWREADY  out  1
S_AXI_WID  in  ID  ignored
S_AXI_WDATA/WSTRB/WLAST/WVALID  in  DATA/DATA/8/1/1  write data
S_AXI_WREADY  out  1
S_AXI_BID/BRESP/BVALID  out  ID/2/1;  S_AXI_BREADY  in  1
S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID/ADDR/8/3/2  read address
S_AXI_ARLOCK/ARCACHE/ARPROT/ARQOS  in  1/4/3/4  accepted, ignored
S_AXI_ARVALID  in  1;  S_AXI_ARREADY  out  1
S_AXI_RID/RDATA/RRESP/RLAST/RVALID  out  ID/DATA/2/1/1;  S_AXI_RREADY  in  1

Behaviour:
- Reset (synchronous, active-high): both FSMs go to IDLE. All outputs are 0 while S_AXI_ARESET=1. AWREADY and ARREADY go to 1 on the first cycle after release. RAM contents are preserved, not cleared.
- Word index: idx = ADDR[MEM_DEPTH_LOG2+B-1:B], with B = log2(DATA_WIDTH/8). Higher address bits are ignored, so addresses alias. Low B bits are ignored (aligned transfers only). AxSIZE is ignored; full-width beats are assumed.
- Burst addressing: AxBURST=00 (FIXED) holds idx; any other value increments idx per beat, wrapping modulo 2^MEM_DEPTH_LOG2.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, capture idx, AWLEN, AWID and AWBURST, then go to W_DATA. AWREADY drops the next cycle.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes the RAM with byte enables from WSTRB and advances the beat counter.
  - Burst end is the beat where count==AWLEN, regardless of WLAST.
  - Error flag: set if WLAST=1 on an earlier beat or WLAST=0 on the final beat.
  - W_RESP: WREADY=0, BVALID=1, BID=captured ID, BRESP=2'b10 if the error flag is set, else 2'b00. Hold until BREADY, then go to W_IDLE.
  - Minimum AW handshake to next AWREADY: AWLEN+3 cycles.
- Read FSM R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: ARREADY=1. On handshake, capture idx, ARLEN, ARID and ARBURST.
  - R_FETCH: one cycle, issues the RAM read.
  - R_DATA: RVALID=1 with registered RDATA. AR handshake at cycle T gives first RVALID at T+2.
  - On RVALID&RREADY, the next word is already presented the following cycle, giving one beat per cycle under continuous RREADY.
  - With RREADY=0, RDATA/RLAST/RID are held stable.
  - RLAST=1 on beat ARLEN. RRESP is always 2'b00. After the last handshake, RVALID=0 and the FSM returns to R_IDLE.
- Collision: a read and write to the same word in the same cycle returns the old data (read-first).
- Independence: AW/W acceptance never waits on the read side and vice versa. A new AW while busy is simply not accepted (AWREADY=0), and likewise for AR.
- Reset mid-burst: the burst is abandoned, valids go low the next cycle, and no response is issued for it.

Test Plan:
1. Write AWADDR=0x100, AWLEN=3, AWID=5, data 1,2,3,4, WSTRB all-ones, WLAST on beat 4 -> BVALID with BID=5, BRESP=00. Then read ARADDR=0x100, ARLEN=3, ARID=2 -> RDATA 1,2,3,4 in 4 consecutive cycles, RLAST on the 4th, RID=2, first RVALID exactly 2 cycles after the AR handshake.
2. FDMA-style 100-beat transfer: bursts AWLEN=63 @0x400, then AWLEN=35 @0x800 -> read-back of 100 words from 0x400 matches, with no gaps in R under RREADY=1.
3. Word holds 0xFFFF..FF; write 0 with WSTRB=16'h00FF -> read-back gives bytes 15..8 = 0xFF and bytes 7..0 = 0x00.
4. AWLEN=3 with WLAST asserted on beat 2 -> all 4 beats are accepted and BRESP=2'b10. A following normal burst returns BRESP=00.
5. Backpressure: RREADY toggled 1,0,1,0 during an 8-beat read -> all 8 words arrive in order and RDATA is stable while stalled. BREADY held 0 for 5 cycles -> BVALID/BID/BRESP are held, and AWREADY stays 0 until the B handshake.
6. Reset asserted at read beat 3 of 8 -> RVALID=0 the next cycle and ARREADY=1 one cycle after release. A fresh read then returns the previously written data.
